// File: rtl/tv80_mem_bridge.sv
// tv80_mem_bridge: adapts the tv80s CPU bus to a synchronous single-port RAM.
// Optional macro TV80_BRIDGE_IO_WINDOW_EN maps I/O ports into RAM page IO_PAGE.
`default_nettype none

module tv80_mem_bridge #(
  parameter int         WAIT_STATES = 1,
  parameter logic [7:0] IO_PAGE     = 8'h10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_do,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  output logic [7:0]  cpu_di,
  output logic        wait_n,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_re,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DATA  = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam logic [2:0] c_WAIT = 3'(WAIT_STATES);

`ifdef TV80_BRIDGE_IO_WINDOW_EN
  localparam logic c_IO_WIN = 1'b1;
`else
  localparam logic c_IO_WIN = 1'b0;
`endif

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_di;
  logic        r_wr;
  logic [2:0]  r_cnt;

  logic w_rw;
  logic w_mem;
  logic w_io;
  logic w_inta;

  // Memory wins when MREQ and IORQ are both low; refresh has no strobe and is ignored.
  assign w_rw   = !rd_n || !wr_n;
  assign w_mem  = !mreq_n && w_rw;
  assign w_io   = mreq_n && !iorq_n && m1_n && w_rw;
  assign w_inta = mreq_n && !iorq_n && !m1_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    ram_re = 1'b0;
    ram_we = 1'b0;
    wait_n = 1'b1;
    busy   = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_mem) begin
          w_next = S_ISSUE;
        end else if (w_inta) begin
          w_next = S_HOLD;
        end else if (w_io) begin
          w_next = c_IO_WIN ? S_ISSUE : S_HOLD;
        end
      end
      S_ISSUE: begin
        // Strobes are a pure state decode so an async reset kills them instantly.
        ram_re = !r_wr;
        ram_we = r_wr;
        wait_n = 1'b0;
        w_next = S_DATA;
      end
      S_DATA: begin
        wait_n = 1'b0;
        w_next = (c_WAIT != 3'd0) ? S_WAIT : S_HOLD;
      end
      S_WAIT: begin
        wait_n = 1'b0;
        if (r_cnt <= 3'd1) begin
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (mreq_n && iorq_n) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= 16'h0000;
      r_wdata <= 8'h00;
      r_wr    <= 1'b0;
      r_di    <= 8'hFF;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mem || w_io) begin
            r_addr  <= w_mem ? cpu_a : {IO_PAGE, cpu_a[7:0]};
            r_wdata <= cpu_do;
            r_wr    <= !wr_n;
            // Unmapped I/O reads float high.
            if (w_io && !c_IO_WIN && wr_n) begin
              r_di <= 8'hFF;
            end
          end else if (w_inta) begin
            r_di <= 8'hFF;
          end
        end
        S_DATA: begin
          if (!r_wr) begin
            r_di <= ram_rdata;
          end
          r_cnt <= c_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign cpu_di    = r_di;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_tv80_mem_bridge.sv
// Scoreboard bench for tv80_mem_bridge: randomized CPU bus cycles vs. a transaction-level model.
`default_nettype none

module tb_tv80_mem_bridge;

  localparam int         WS      = 1;
  localparam logic [7:0] IO_PG   = 8'h10;
`ifdef TV80_BRIDGE_IO_WINDOW_EN
  localparam bit         IO_WIN  = 1'b1;
`else
  localparam bit         IO_WIN  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n;
  logic [7:0]  cpu_di;
  logic        wait_n;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_re, ram_we;
  logic [7:0]  ram_rdata;
  logic        busy;

  tv80_mem_bridge #(.WAIT_STATES(WS), .IO_PAGE(IO_PG)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_do(cpu_do),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .cpu_di(cpu_di), .wait_n(wait_n), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_we(ram_we), .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Background RAM contents before any write.
  function automatic logic [7:0] init_fn(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5C;
  endfunction

  bit [7:0] env_ram [0:65535];
  bit       env_v   [0:65535];
  always @(posedge clk) begin
    if (ram_we) begin
      env_ram[ram_addr] <= ram_wdata;
      env_v[ram_addr]   <= 1'b1;
    end
    ram_rdata <= env_v[ram_addr] ? env_ram[ram_addr] : init_fn(ram_addr);
  end

  typedef struct { logic we; logic [15:0] a; logic [7:0] d; } strobe_t;
  typedef struct { logic [7:0] di; int lows; } done_t;
  strobe_t sq[$];
  done_t   dq[$];

  logic [7:0] ref_mem [int];
  logic [7:0] exp_di;
  int n_pass = 0;
  int n_tot  = 0;
  bit mon_off = 1'b1;
  int m_lows;
  bit m_prev;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_fn(a);
  endfunction

  // Monitor: pops expectations whenever the DUT strobes RAM or completes a cycle.
  initial begin
    strobe_t s;
    done_t   d;
    bit      hold;
    m_lows = 0;
    m_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n || mon_off) begin
        m_lows = 0;
        m_prev = 1'b0;
      end else begin
        if (ram_re || ram_we) begin
          if (sq.size() == 0) begin
            chk(1'b0, "unexpected_strobe", 32'({ram_we, ram_re}), 32'd0);
          end else begin
            s = sq.pop_front();
            chk(ram_we == s.we && ram_re == !s.we, "strobe_dir", 32'({ram_we, ram_re}), 32'({s.we, !s.we}));
            chk(ram_addr == s.a, "strobe_addr", 32'(ram_addr), 32'(s.a));
            if (s.we) chk(ram_wdata == s.d, "strobe_wdata", 32'(ram_wdata), 32'(s.d));
          end
        end
        if (!wait_n) m_lows++;
        hold = busy && wait_n;
        if (hold && !m_prev) begin
          if (dq.size() == 0) begin
            chk(1'b0, "unexpected_done", 32'(cpu_di), 32'd0);
          end else begin
            d = dq.pop_front();
            chk(cpu_di == d.di, "cpu_di", 32'(cpu_di), 32'(d.di));
            chk(m_lows == d.lows, "wait_low_cycles", 32'(m_lows), 32'(d.lows));
          end
          m_lows = 0;
        end
        m_prev = hold;
      end
    end
  end

  task automatic bus_idle();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
  endtask

  // kind: 0 mem rd, 1 mem wr, 2 io rd, 3 io wr, 4 int ack, 5 mem+io rd, 6 mem+io wr
  task automatic access(input int kind, input logic [15:0] a, input logic [7:0] d);
    bit          is_io = (kind == 2 || kind == 3);
    bit          wr    = (kind == 1 || kind == 3 || kind == 6);
    bit          mem   = (kind == 0 || kind == 1 || kind == 5 || kind == 6);
    logic [15:0] ea;
    int          i;
    if (kind == 4) begin
      exp_di = 8'hFF;
      dq.push_back('{8'hFF, 0});
    end else if (is_io && !IO_WIN) begin
      if (!wr) exp_di = 8'hFF;
      dq.push_back('{exp_di, 0});
    end else begin
      ea = is_io ? {IO_PG, a[7:0]} : a;
      if (wr) begin
        sq.push_back('{1'b1, ea, d});
        ref_mem[int'(ea)] = d;
      end else begin
        sq.push_back('{1'b0, ea, 8'h00});
        exp_di = ref_rd(ea);
      end
      dq.push_back('{exp_di, 2 + WS});
    end
    @(negedge clk);
    cpu_a  = a;
    cpu_do = d;
    mreq_n = !mem;
    iorq_n = mem ? !(kind == 5 || kind == 6) : !(is_io || kind == 4);
    m1_n   = (kind != 4);
    rd_n   = !(kind != 4 && !wr);
    wr_n   = !wr;
    for (i = 0; i < 40 && !(busy && wait_n); i++) @(negedge clk);
    chk(busy && wait_n, "reach_hold", 32'({busy, wait_n}), 32'h3);
    bus_idle();
    for (i = 0; i < 5 && busy; i++) @(negedge clk);
    chk(!busy, "return_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  old;
    logic [7:0]  hi, lo;
    exp_di  = 8'hFF;
    cpu_a   = 16'h0000;
    cpu_do  = 8'h00;
    bus_idle();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk(cpu_di == 8'hFF && wait_n && !busy && !ram_re && !ram_we, "reset_outputs",
        32'({cpu_di, wait_n, busy, ram_re, ram_we}), 32'({8'hFF, 4'b1000}));
    chk(ram_addr == 16'h0 && ram_wdata == 8'h0, "reset_ram_port", 32'({ram_addr, ram_wdata}), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk(cpu_di == 8'hFF && wait_n && !busy && !ram_re && !ram_we, "post_reset",
        32'({cpu_di, wait_n, busy, ram_re, ram_we}), 32'({8'hFF, 4'b1000}));
    mon_off = 1'b0;

    access(1, 16'h43F7, 8'hE9);
    access(0, 16'h43F7, 8'h00);
    access(1, 16'h1234, 8'h5A);
    access(3, 16'h0022, 8'h77);
    access(2, 16'h0022, 8'h00);
    access(1, 16'hFFFF, 8'hC3);
    access(0, 16'hFFFF, 8'h00);
    access(5, 16'h1234, 8'h00);
    access(4, 16'h0038, 8'h00);

    // Refresh must not wake the bridge.
    @(negedge clk);
    mreq_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk(!busy, "refresh_busy", 32'(busy), 32'd0);
    end
    bus_idle();
    access(0, 16'h1234, 8'h00);

    // Reset landing in the ISSUE cycle of a write.
    a   = 16'h0ABC;
    old = ref_rd(a);
    mon_off = 1'b1;
    @(negedge clk);
    cpu_a = a; cpu_do = ~old; mreq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk);
    #1;
    chk(ram_we, "issue_we", 32'(ram_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk(!ram_we && !ram_re && !busy && wait_n, "reset_abort",
        32'({ram_we, ram_re, busy, wait_n}), 32'h1);
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    reset_n = 1'b1;
    exp_di  = 8'hFF;
    @(negedge clk);
    mon_off = 1'b0;
    access(0, a, 8'h00);

    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 2))
        0:       hi = IO_PG;
        1:       hi = 8'h43;
        default: hi = 8'hFF;
      endcase
      case ($urandom_range(0, 3))
        0:       lo = 8'h22;
        1:       lo = 8'hF7;
        2:       lo = 8'hFF;
        default: lo = 8'h00;
      endcase
      access(int'($urandom_range(0, 6)), {hi, lo}, 8'($urandom_range(0, 255)));
    end

    repeat (5) @(negedge clk);
    chk(sq.size() == 0, "strobe_queue_drained", 32'(sq.size()), 32'd0);
    chk(dq.size() == 0, "done_queue_drained", 32'(dq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
